// File: rtl/uart_core_if.sv
// uart_core_if: transmit handshake, serial pins and receive result bundle for uart_core
interface uart_core_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_busy;
  logic txd;
  logic rxd;
  logic loopback;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_parity_err;
  logic rx_frame_err;
  modport master (
    output tx_data, tx_valid, rxd, loopback,
    input tx_ready, tx_busy, txd, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );
  modport slave (
    input tx_data, tx_valid, rxd, loopback,
    output tx_ready, tx_busy, txd, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with shared oversampling tick, parity/stop options and loopback
module uart_core #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst,
  uart_core_if.slave u
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int BAUD_DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {T_IDLE, T_ARM, T_START, T_DATA, T_PAR, T_STOP} tx_st_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_st_e;
  logic [DW-1:0] div_q, div_d;
  logic tick;
  tx_st_e tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic tx_par_q, tx_par_d;
  logic tx_bit_end, tx_ready, tx_accept, txd;
  rx_st_e rx_st_q, rx_st_d;
  logic [2:0] rx_sync_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic rx_par_q, rx_par_d;
  logic rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic rx_src, rx_line, rx_fall, rx_samp;
  always_comb begin
    tick = div_q == DW'(BAUD_DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
  end
  // Ready rises in the last cycle of the final stop period so a held tx_valid chains frames with no gap
  always_comb begin
    tx_bit_end = tick && tx_cnt_q == OS_LAST;
    tx_ready = tx_st_q == T_IDLE || (tx_st_q == T_STOP && tx_bit_end && tx_bit_q == SB_LAST);
    tx_accept = u.tx_valid && tx_ready;
    txd = tx_st_q == T_START ? 1'b0 : tx_st_q == T_DATA ? tx_sh_q[0] : tx_st_q == T_PAR ? tx_par_q : 1'b1;
  end
  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    if (tick && !(tx_st_q inside {T_IDLE, T_ARM})) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_st_q)
      T_ARM: if (tick) tx_st_d = T_START;
      T_START: if (tx_bit_end) tx_st_d = T_DATA;
      T_DATA: if (tx_bit_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q == DB_LAST ? '0 : tx_bit_q + 1'b1;
        if (tx_bit_q == DB_LAST) tx_st_d = PARITY == 0 ? T_STOP : T_PAR;
      end
      T_PAR: if (tx_bit_end) tx_st_d = T_STOP;
      T_STOP: if (tx_bit_end) begin
        tx_bit_d = tx_bit_q == SB_LAST ? '0 : tx_bit_q + 1'b1;
        if (tx_bit_q == SB_LAST) tx_st_d = T_IDLE;
      end
      default: tx_st_d = tx_st_q;
    endcase
    if (tx_accept) begin
      tx_st_d = tick ? T_START : T_ARM;
      tx_cnt_d = '0;
      tx_bit_d = '0;
      tx_sh_d = u.tx_data;
      tx_par_d = PARITY == 1 ? ~^u.tx_data : ^u.tx_data;
    end
  end
  always_comb begin
    rx_src = u.loopback ? txd : u.rxd;
    rx_line = rx_sync_q[1];
    rx_fall = rx_sync_q[2] && !rx_sync_q[1];
    rx_samp = tick && rx_cnt_q == (rx_st_q == R_START ? OS_HALF : OS_LAST);
  end
  // Start is qualified at half a bit, then every later sample lands mid-bit
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_par_d = rx_par_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d = rx_perr_q;
    rx_ferr_d = rx_ferr_q;
    if (tick && rx_st_q != R_IDLE) rx_cnt_d = rx_samp ? '0 : rx_cnt_q + 1'b1;
    case (rx_st_q)
      R_IDLE: if (rx_fall) begin
        rx_st_d = R_START;
        rx_cnt_d = '0;
      end
      R_START: if (rx_samp) begin
        rx_st_d = rx_line ? R_IDLE : R_DATA;
        rx_bit_d = '0;
      end
      R_DATA: if (rx_samp) begin
        rx_sh_d = {rx_line, rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == DB_LAST) rx_st_d = PARITY == 0 ? R_STOP : R_PAR;
      end
      R_PAR: if (rx_samp) begin
        rx_par_d = rx_line;
        rx_st_d = R_STOP;
      end
      R_STOP: if (rx_samp) begin
        rx_st_d = R_IDLE;
        rx_valid_d = 1'b1;
        rx_data_d = rx_sh_q;
        rx_ferr_d = !rx_line;
        rx_perr_d = PARITY != 0 && rx_par_q != (PARITY == 1 ? ~^rx_sh_q : ^rx_sh_q);
      end
      default: rx_st_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_q <= '0;
      tx_st_q <= T_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_par_q <= 1'b0;
      rx_st_q <= R_IDLE;
      rx_sync_q <= '1;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_par_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d;
      rx_st_q <= rx_st_d;
      rx_sync_q <= {rx_sync_q[1:0], rx_src};
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_par_q <= rx_par_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q <= rx_perr_d;
      rx_ferr_q <= rx_ferr_d;
    end
  assign u.tx_ready = tx_ready;
  assign u.tx_busy = !tx_ready;
  assign u.txd = txd;
  assign u.rx_data = rx_data_q;
  assign u.rx_valid = rx_valid_q;
  assign u.rx_parity_err = rx_perr_q;
  assign u.rx_frame_err = rx_ferr_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks on three uart_core builds (8N1, 8E1, 8N2), 16 clk per bit
module tb_uart_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] tx_data [3];
  logic tx_valid [3], rxd [3], loopback [3];
  logic txd [3], tx_ready [3], tx_busy [3], rx_valid [3], perr [3], ferr [3];
  logic [7:0] rx_data [3];
  int n_chk = 0, n_fail = 0;
  int rx_cnt [3] = '{0, 0, 0};
  logic [7:0] got2 [4];
  uart_core_if #(.DATA_BITS(8)) ifs [3] ();
  for (genvar g = 0; g < 3; g++) begin : g_if
    assign ifs[g].tx_data = tx_data[g];
    assign ifs[g].tx_valid = tx_valid[g];
    assign ifs[g].rxd = rxd[g];
    assign ifs[g].loopback = loopback[g];
    assign txd[g] = ifs[g].txd;
    assign tx_ready[g] = ifs[g].tx_ready;
    assign tx_busy[g] = ifs[g].tx_busy;
    assign rx_valid[g] = ifs[g].rx_valid;
    assign rx_data[g] = ifs[g].rx_data;
    assign perr[g] = ifs[g].rx_parity_err;
    assign ferr[g] = ifs[g].rx_frame_err;
  end
  uart_core #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16)) d0 (.clk(clk), .rst(rst), .u(ifs[0]));
  uart_core #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16), .PARITY(2)) d1 (.clk(clk), .rst(rst), .u(ifs[1]));
  uart_core #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16), .STOP_BITS(2)) d2 (.clk(clk), .rst(rst), .u(ifs[2]));
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (rx_valid[k]) begin
        if (k == 2 && rx_cnt[2] < 4) got2[rx_cnt[2]] = rx_data[2];
        rx_cnt[k]++;
      end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic send(input int k, input logic [7:0] b);
    tx_data[k] = b;
    tx_valid[k] = 1'b1;
    for (int i = 0; i < 400 && !tx_ready[k]; i++) @(negedge clk);
    @(negedge clk);
    tx_valid[k] = 1'b0;
  endtask
  task automatic wait_rx(input int k, input int n);
    for (int i = 0; i < 400 && rx_cnt[k] < n; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rx_count", rx_cnt[k], n);
  endtask
  task automatic put_bit(input int k, input logic v);
    rxd[k] = v;
    repeat (16) @(negedge clk);
  endtask
  task automatic drive_frame(input int k, input logic [7:0] b, input bit par_en, input logic par, input logic stop);
    put_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(k, b[i]);
    if (par_en) put_bit(k, par);
    put_bit(k, stop);
    rxd[k] = 1'b1;
    repeat (32) @(negedge clk);
  endtask
  initial begin
    logic [15:0] bit_v;
    logic [9:0] exp_bits;
    int rdy_j, low_j;
    for (int k = 0; k < 3; k++) begin
      tx_data[k] = '0;
      tx_valid[k] = 1'b0;
      rxd[k] = 1'b1;
      loopback[k] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd[0], 1);
    check("rst_tx_ready", tx_ready[0], 1);
    check("rst_tx_busy", tx_busy[0], 0);
    check("rst_rx_data", rx_data[0], 0);
    check("rst_rx_valid", rx_valid[0], 0);
    check("rst_perr", perr[0], 0);
    check("rst_ferr", ferr[0], 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    loopback[0] = 1'b1;
    send(0, 8'h55);
    exp_bits = 10'b1010101010;
    rdy_j = -1;
    for (int j = 0; j < 160; j++) begin
      bit_v[j % 16] = txd[0];
      if (j == 8) check("t1_busy", tx_busy[0], 1);
      if (tx_ready[0] && rdy_j < 0) rdy_j = j;
      if (j % 16 == 15) check($sformatf("t1_txd_bit%0d", j / 16), bit_v, {16{exp_bits[j / 16]}});
      @(negedge clk);
    end
    check("t1_ready_clk", rdy_j, 159);
    wait_rx(0, 1);
    repeat (40) @(negedge clk);
    check("t1_rx_once", rx_cnt[0], 1);
    check("t1_rx_data", rx_data[0], 8'h55);
    check("t1_perr", perr[0], 0);
    check("t1_ferr", ferr[0], 0);
    loopback[0] = 1'b0;
    loopback[1] = 1'b1;
    send(1, 8'h07);
    repeat (152) @(negedge clk);
    check("t2_par_bit", txd[1], 1);
    wait_rx(1, 1);
    check("t2_rx_data", rx_data[1], 8'h07);
    check("t2_perr", perr[1], 0);
    check("t2_ferr", ferr[1], 0);
    repeat (32) @(negedge clk);
    loopback[1] = 1'b0;
    repeat (16) @(negedge clk);
    drive_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_rx(1, 2);
    check("t2_bad_perr", perr[1], 1);
    check("t2_bad_data", rx_data[1], 8'h07);
    check("t2_bad_ferr", ferr[1], 0);
    drive_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0);
    wait_rx(0, 2);
    check("t3_data", rx_data[0], 8'hA3);
    check("t3_ferr", ferr[0], 1);
    check("t3_perr", perr[0], 0);
    drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_rx(0, 3);
    check("t3_clean_data", rx_data[0], 8'h3C);
    check("t3_clean_ferr", ferr[0], 0);
    rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("t4_no_valid", rx_cnt[0], 3);
    drive_frame(0, 8'h41, 1'b0, 1'b0, 1'b1);
    wait_rx(0, 4);
    check("t4_data", rx_data[0], 8'h41);
    check("t4_ferr", ferr[0], 0);
    loopback[2] = 1'b1;
    tx_data[2] = 8'h31;
    tx_valid[2] = 1'b1;
    @(negedge clk);
    tx_data[2] = 8'h32;
    low_j = -1;
    for (int j = 0; j < 200; j++) begin
      if (j >= 144 && !txd[2] && low_j < 0) begin
        low_j = j;
        tx_valid[2] = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid[2] = 1'b0;
    check("t5_gap", low_j - 144, 32);
    wait_rx(2, 2);
    check("t5_word0", got2[0], 8'h31);
    check("t5_word1", got2[1], 8'h32);
    loopback[0] = 1'b1;
    send(0, 8'hFF);
    repeat (70) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_txd", txd[0], 1);
    check("t6_ready", tx_ready[0], 1);
    check("t6_busy", tx_busy[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("t6_no_valid", rx_cnt[0], 4);
    send(0, 8'h12);
    wait_rx(0, 5);
    check("t6_data", rx_data[0], 8'h12);
    check("t6_ferr", ferr[0], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
